// File: rtl/dino_motion_ctrl.sv
// Dino sprite motion controller: frame-rate jump physics, duck and run animation.
// Optional build macro DINO_FAST_FALL_EN: holding duck while airborne doubles gravity.
module dino_motion_ctrl #(
    parameter logic [9:0] GROUND_Y = 10'd200,
    parameter logic [7:0] JUMP_V0  = 8'd12,
    parameter logic [7:0] GRAVITY  = 8'd1,
    parameter int         ANIM_DIV = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_vs,
    input  logic        jump_req,
    input  logic        duck,
    output logic [9:0]  dino_y,
    output logic [1:0]  sprite_sel,
    output logic        anim_frame,
    output logic        airborne,
    output logic [15:0] jump_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DUCK = 2'd1,
        AIR  = 2'd2
    } state_t;

    localparam int               DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

    state_t            state_reg;
    logic              vs_q_reg;
    logic              jump_pend_reg;
    logic signed [7:0] vel_reg;
    logic [DIV_W-1:0]  div_reg;

    logic               frame_tick;
    logic               jump_now;
    logic [8:0]         grav_dec;
    logic signed [11:0] next_y;
    logic               land;
    logic [9:0]         air_y;
    logic [9:0]         takeoff_y;
    logic signed [7:0]  air_vel;
    logic signed [7:0]  takeoff_vel;

    // Velocity minus a positive decrement, clamped at the most negative value.
    function automatic logic signed [7:0] sat_sub(input logic signed [7:0] v,
                                                  input logic [8:0] d);
        logic signed [9:0] t;
        t = $signed({{2{v[7]}}, v}) - $signed({1'b0, d});
        if (t < -10'sd128)
            return -8'sd128;
        return $signed(t[7:0]);
    endfunction

    assign frame_tick = vs_q_reg & ~vga_vs;
    assign jump_now   = jump_pend_reg | jump_req;

`ifdef DINO_FAST_FALL_EN
    assign grav_dec = duck ? {GRAVITY, 1'b0} : {1'b0, GRAVITY};
`else
    assign grav_dec = {1'b0, GRAVITY};
`endif

    assign next_y = $signed({2'b00, dino_y}) - $signed({{4{vel_reg[7]}}, vel_reg});
    assign land   = vel_reg[7] && (next_y >= $signed({2'b00, GROUND_Y}));
    assign air_y  = next_y[11] ? 10'd0 : next_y[9:0];
    assign air_vel = sat_sub(vel_reg, grav_dec);

    // The take-off frame already moves the sprite, so the arc starts on the jump frame.
    assign takeoff_y   = GROUND_Y - {2'b00, JUMP_V0};
    assign takeoff_vel = sat_sub($signed(JUMP_V0), {1'b0, GRAVITY});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RUN;
            vs_q_reg      <= 1'b1;
            jump_pend_reg <= 1'b0;
            vel_reg       <= '0;
            div_reg       <= '0;
            dino_y        <= GROUND_Y;
            sprite_sel    <= 2'd0;
            anim_frame    <= 1'b0;
            airborne      <= 1'b0;
            jump_count    <= '0;
        end else begin
            vs_q_reg <= vga_vs;
            if (frame_tick) begin
                jump_pend_reg <= 1'b0;
                case (state_reg)
                    RUN: begin
                        if (jump_now) begin
                            state_reg  <= AIR;
                            dino_y     <= takeoff_y;
                            vel_reg    <= takeoff_vel;
                            sprite_sel <= 2'd1;
                            airborne   <= 1'b1;
                            div_reg    <= '0;
                        end else if (duck) begin
                            state_reg  <= DUCK;
                            sprite_sel <= 2'd2;
                            div_reg    <= '0;
                        end else if (div_reg == DIV_LAST) begin
                            div_reg    <= '0;
                            anim_frame <= ~anim_frame;
                        end else begin
                            div_reg <= div_reg + 1'b1;
                        end
                    end
                    DUCK: begin
                        dino_y  <= GROUND_Y;
                        div_reg <= '0;
                        if (!duck) begin
                            state_reg  <= RUN;
                            sprite_sel <= 2'd0;
                        end
                    end
                    AIR: begin
                        div_reg <= '0;
                        if (land) begin
                            state_reg  <= RUN;
                            dino_y     <= GROUND_Y;
                            vel_reg    <= '0;
                            sprite_sel <= 2'd0;
                            airborne   <= 1'b0;
                            if (jump_count != 16'hFFFF)
                                jump_count <= jump_count + 16'd1;
                        end else begin
                            dino_y  <= air_y;
                            vel_reg <= air_vel;
                        end
                    end
                    default: begin
                        state_reg  <= RUN;
                        dino_y     <= GROUND_Y;
                        vel_reg    <= '0;
                        sprite_sel <= 2'd0;
                        airborne   <= 1'b0;
                        div_reg    <= '0;
                    end
                endcase
            end else if (jump_req) begin
                jump_pend_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Testbench for dino_motion_ctrl: vector table driven through a frame-tick task,
// expected outputs queued as a scoreboard and checked one frame later.
module tb_dino_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vga_vs = 1'b1;
    logic        jump_req = 1'b0;
    logic        duck = 1'b0;
    logic [9:0]  dino_y;
    logic [1:0]  sprite_sel;
    logic        anim_frame;
    logic        airborne;
    logic [15:0] jump_count;

    always #5 clk = ~clk;

    dino_motion_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vga_vs    (vga_vs),
        .jump_req  (jump_req),
        .duck      (duck),
        .dino_y    (dino_y),
        .sprite_sel(sprite_sel),
        .anim_frame(anim_frame),
        .airborne  (airborne),
        .jump_count(jump_count)
    );

    // jr: 0 none, 1 pulse on a non-tick cycle before the frame, 2 pulse on the tick cycle
    typedef struct {
        logic [1:0]  jr;
        logic        dk;
        logic [9:0]  y;
        logic [1:0]  sel;
        logic        anim;
        logic        air;
        logic [15:0] cnt;
        string       name;
    } vec_t;

    typedef struct {
        logic [9:0]  y;
        logic [1:0]  sel;
        logic        anim;
        logic        air;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    int traj[25] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123, 122, 122,
                     123, 125, 128, 132, 137, 143, 150, 158, 167, 177, 188, 200};
    int fast[21] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123,
                     122, 123, 126, 131, 138, 147, 158, 171, 186, 200};

    function automatic vec_t mk(input logic [1:0] jr, input logic dk, input int y,
                                input logic [1:0] sel, input logic anim, input logic air,
                                input int cnt, input string name);
        vec_t v;
        v.jr = jr; v.dk = dk; v.y = 10'(y); v.sel = sel;
        v.anim = anim; v.air = air; v.cnt = 16'(cnt); v.name = name;
        return v;
    endfunction

    task automatic push_exp(input int y, input logic [1:0] sel, input logic anim,
                            input logic air, input int cnt);
        exp_t e;
        e.y = 10'(y); e.sel = sel; e.anim = anim; e.air = air; e.cnt = 16'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, no expected value", name);
        end else begin
            e = sb_q.pop_front();
            if (dino_y !== e.y || sprite_sel !== e.sel || anim_frame !== e.anim ||
                airborne !== e.air || jump_count !== e.cnt) begin
                miscompares++;
                $display("FAIL %s: got y=%0d sel=%0d anim=%0b air=%0b cnt=%0d, expected y=%0d sel=%0d anim=%0b air=%0b cnt=%0d",
                         name, dino_y, sprite_sel, anim_frame, airborne, jump_count,
                         e.y, e.sel, e.anim, e.air, e.cnt);
            end else begin
                $display("ok   %s: y=%0d sel=%0d anim=%0b air=%0b cnt=%0d",
                         name, dino_y, sprite_sel, anim_frame, airborne, jump_count);
            end
        end
    endtask

    // One vertical-sync falling edge; outputs are sampled on the frame after the tick.
    task automatic do_tick(input vec_t v);
        push_exp(v.y, v.sel, v.anim, v.air, v.cnt);
        @(negedge clk);
        duck   = v.dk;
        vga_vs = 1'b1;
        if (v.jr == 2'd1) jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
        vga_vs   = 1'b0;
        if (v.jr == 2'd2) jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
        check_out(v.name);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Steady running: anim toggles on the 6th and 12th frame.
        for (int i = 1; i <= 12; i++)
            tbl.push_back(mk(0, 0, 200, 0, (i >= 6 && i < 12), 0, 0, $sformatf("run t%0d", i)));
        // Jump with extra requests during flight that must be discarded.
        for (int i = 1; i <= 25; i++)
            tbl.push_back(mk((i == 1 || i == 3) ? 2'd1 : (i == 7) ? 2'd2 : 2'd0, 0, traj[i-1],
                             (i < 25) ? 2'd1 : 2'd0, 0, (i < 25), (i == 25) ? 1 : 0,
                             $sformatf("jump1 t%0d", i)));
        tbl.push_back(mk(0, 0, 200, 0, 0, 0, 1, "after land"));
        // Duck: a request while ducking is dropped.
        tbl.push_back(mk(0, 1, 200, 2, 0, 0, 1, "duck enter"));
        tbl.push_back(mk(1, 1, 200, 2, 0, 0, 1, "duck jump ignored"));
        tbl.push_back(mk(0, 0, 200, 0, 0, 0, 1, "duck release"));
        tbl.push_back(mk(0, 0, 200, 0, 0, 0, 1, "run no stale jump"));
        // Second jump, request on the tick cycle, duck held from frame 12.
`ifdef DINO_FAST_FALL_EN
        for (int i = 1; i <= 21; i++)
            tbl.push_back(mk((i == 1) ? 2'd2 : 2'd0, (i >= 12), fast[i-1],
                             (i < 21) ? 2'd1 : 2'd0, 0, (i < 21), (i == 21) ? 2 : 1,
                             $sformatf("jump2 fast t%0d", i)));
`else
        for (int i = 1; i <= 25; i++)
            tbl.push_back(mk((i == 1) ? 2'd2 : 2'd0, (i >= 12), traj[i-1],
                             (i < 25) ? 2'd1 : 2'd0, 0, (i < 25), (i == 25) ? 2 : 1,
                             $sformatf("jump2 duck t%0d", i)));
`endif
        tbl.push_back(mk(0, 0, 200, 0, 0, 0, 2, "after land2"));

        // Reset state.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push_exp(200, 0, 0, 0, 0);
        check_out("reset state");

        for (int i = 0; i < 12; i++)
            do_tick(tbl[i]);

        // vga_vs held low with no falling edge: nothing may move.
        push_exp(200, 0, 0, 0, 0);
        @(negedge clk);
        vga_vs = 1'b0;
        duck   = 1'b1;
        repeat (20) @(negedge clk);
        duck = 1'b0;
        @(negedge clk);
        check_out("vs low idle");

        for (int i = 12; i < tbl.size(); i++)
            do_tick(tbl[i]);

        // Reset mid-jump, asserted between clock edges.
        for (int i = 1; i <= 6; i++)
            do_tick(mk((i == 1) ? 2'd1 : 2'd0, 0, traj[i-1], 1, 0, 1, 2,
                       $sformatf("jump3 t%0d", i)));
        @(negedge clk);
        jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
        vga_vs   = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        push_exp(200, 0, 0, 0, 0);
        check_out("async reset mid-jump");
        @(negedge clk);
        reset_n = 1'b1;
        do_tick(mk(0, 0, 200, 0, 0, 0, 0, "first tick after reset"));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dino_motion_ctrl.md
DINO_MOTION_CTRL -- requirements
Module: dino_motion_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter GROUND_Y, default 10'd200: resting top-row y of dino sprite.
REQ-002 SHALL have parameter JUMP_V0, default 8'd12: initial upward velocity, pixels/frame.
REQ-003 SHALL have parameter GRAVITY, default 8'd1: velocity decrement per frame.
REQ-004 SHALL have parameter ANIM_DIV, default 6: frames per run-animation toggle.

Ports (name, direction, width, meaning):
REQ-005 SHALL have port clk, in, 1: single clock, 50 MHz domain of the display stage.
REQ-006 SHALL have port reset_n, in, 1: asynchronous, active-low reset.
REQ-007 SHALL have port vga_vs, in, 1: VGA_VS from counters; active-low vertical sync.
REQ-008 SHALL have port jump_req, in, 1: one-cycle jump request pulse (host register write).
REQ-009 SHALL have port duck, in, 1: duck level, held by host.
REQ-010 SHALL have port dino_y, out, 10: sprite y fed to the sprite display stage.
REQ-011 SHALL have port sprite_sel, out, 2: 0 run, 1 jump, 2 duck; 3 unused.
REQ-012 SHALL have port anim_frame, out, 1: run animation phase.
REQ-013 SHALL have port airborne, out, 1: high while in AIR.
REQ-014 SHALL have port jump_count, out, 16: completed landings, saturating at 16'hFFFF.

Function
REQ-015 SHALL generate internal frame_tick: one-cycle pulse on the clk after vga_vs is sampled 1 then 0 (falling edge); all motion updates occur only on frame_tick.
REQ-016 SHALL latch jump_req into jump_pend on any cycle; clear jump_pend on each frame_tick after evaluation.
REQ-017 SHALL implement FSM states RUN, DUCK, AIR.
REQ-018 RUN on tick: jump_pend -> AIR, vel=JUMP_V0; else duck -> DUCK; else stay.
REQ-019 DUCK on tick: duck low -> RUN; jump_pend ignored and cleared; dino_y held at GROUND_Y.
REQ-020 AIR on tick: next_y = dino_y - vel (11-bit signed); if vel < 0 and next_y >= GROUND_Y -> dino_y=GROUND_Y, vel=0, RUN, jump_count++; else dino_y = max(next_y,0), vel = vel - GRAVITY.
REQ-021 vel SHALL be 8-bit signed, saturating at -128; jump_pend in AIR SHALL be discarded.
REQ-022 sprite_sel SHALL be a registered function of state: RUN 0, AIR 1, DUCK 2; airborne = (state==AIR).
REQ-023 anim_frame SHALL toggle every ANIM_DIV ticks while in RUN; divider cleared and phase held in AIR and DUCK.
REQ-024 Outputs SHALL change only on the cycle after frame_tick (one-cycle latency) so the display stage sees stable values for an entire frame.
REQ-025 jump_req coincident with frame_tick SHALL be honoured on that tick.

Reset
REQ-026 reset_n low SHALL asynchronously force: state RUN, dino_y=GROUND_Y, vel=0, sprite_sel=0, anim_frame=0, airborne=0, jump_count=0, jump_pend=0, edge register=1, divider=0.
REQ-027 Reset asserted mid-jump SHALL abort the jump; first tick after release behaves as RUN.

Configuration
REQ-028 Macro DINO_FAST_FALL_EN defined: in AIR with duck high, vel decrement SHALL be 2*GRAVITY; sprite_sel stays 1.
REQ-029 DINO_FAST_FALL_EN undefined: duck SHALL be ignored in AIR; decrement is always GRAVITY.

Verification
REQ-030 Defaults, jump_req then 25 ticks -> dino_y 188,177,... peak 122 at tick 12 and 13, lands 200 at tick 25, sprite_sel 1 -> 0, jump_count=1.
REQ-031 duck held in RUN, tick -> sprite_sel=2, dino_y=200; jump_req + tick -> stays DUCK, jump_pend cleared; duck low + tick -> RUN.
REQ-032 jump_req pulses at ticks 3 and 7 of a jump -> ignored; single landing, jump_count=1.
REQ-033 reset_n low at tick 6 of jump -> immediately dino_y=200, sprite_sel=0, airborne=0.
REQ-034 DINO_FAST_FALL_EN, duck held from tick 12 -> landing before tick 25, dino_y exactly 200, no undershoot.
REQ-035 RUN 12 ticks, ANIM_DIV=6 -> anim_frame toggles at ticks 6 and 12; vga_vs held low with no edge -> no updates.
